// File: rtl/busio_if.sv
// busio_if: pipeline handshakes and the external 32-bit valid/ready memory port of busio.
interface busio_if #(parameter int ADDR_WIDTH = 32);
  logic                  fetch_request;
  logic [ADDR_WIDTH-1:0] fetch_address;
  logic [31:0]           fetch_data;
  logic                  fetch_ready;
  logic                  load_store;
  logic                  mem_write;
  logic [1:0]            mem_size;
  logic                  mem_signed;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [31:0]           mem_store_data;
  logic [31:0]           mem_load_data;
  logic                  mem_ready;
  logic                  ext_valid;
  logic                  ext_instruction;
  logic                  ext_write;
  logic [ADDR_WIDTH-1:0] ext_address;
  logic [31:0]           ext_write_data;
  logic [3:0]            ext_write_strobe;
  logic [31:0]           ext_read_data;
  logic                  ext_ready;
  modport slave (
    input  fetch_request, fetch_address, load_store, mem_write, mem_size, mem_signed,
           mem_address, mem_store_data, ext_read_data, ext_ready,
    output fetch_data, fetch_ready, mem_load_data, mem_ready, ext_valid, ext_instruction,
           ext_write, ext_address, ext_write_data, ext_write_strobe
  );
  modport master (
    output fetch_request, fetch_address, load_store, mem_write, mem_size, mem_signed,
           mem_address, mem_store_data, ext_read_data, ext_ready,
    input  fetch_data, fetch_ready, mem_load_data, mem_ready, ext_valid, ext_instruction,
           ext_write, ext_address, ext_write_data, ext_write_strobe
  );
endinterface

// File: rtl/busio.sv
// busio: arbitrates fetch and load/store onto one valid/ready memory port, aligns loads, builds store strobes.
// Optional one-entry last-fetch register enabled by defining BUSIO_FETCH_HIT_EN.
module busio #(
  parameter int          ADDR_WIDTH   = 32,
  parameter logic [31:0] RESET_VECTOR = 32'h0
) (
  input logic   clk,
  input logic   reset_n,
  busio_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, FETCH = 2'd1, MEM = 2'd2, RESP = 2'd3;
  logic [1:0]            r_state;
  logic                  r_is_fetch;
  logic                  r_signed;
  logic [1:0]            r_size;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           w_wdata;
  logic [3:0]            w_strobe;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [31:0]           w_load;
  logic                  w_hit;
  logic [31:0]           w_hit_data;
  logic                  w_fetch_ok;
  logic                  w_mem_ok;
  always_comb begin
    w_wdata  = bus.mem_size[1] ? bus.mem_store_data :
               bus.mem_size[0] ? {2{bus.mem_store_data[15:0]}} : {4{bus.mem_store_data[7:0]}};
    w_strobe = !bus.mem_write ? 4'h0 :
               bus.mem_size[1] ? 4'hF :
               bus.mem_size[0] ? 4'b0011 << {bus.mem_address[1], 1'b0} : 4'b0001 << bus.mem_address[1:0];
    w_byte   = bus.ext_read_data[{r_addr[1:0], 3'b000} +: 8];
    w_half   = r_addr[1] ? bus.ext_read_data[31:16] : bus.ext_read_data[15:0];
    w_load   = r_size[1] ? bus.ext_read_data :
               r_size[0] ? {{16{r_signed & w_half[15]}}, w_half} : {{24{r_signed & w_byte[7]}}, w_byte};
  end
  // A requester that withdrew or moved its address in RESP gets no pulse.
  assign w_fetch_ok    = bus.fetch_request && bus.fetch_address[ADDR_WIDTH-1:2] == r_addr[ADDR_WIDTH-1:2];
  assign w_mem_ok      = bus.load_store && bus.mem_address == r_addr;
  assign bus.fetch_ready = r_state == RESP && r_is_fetch && w_fetch_ok;
  assign bus.mem_ready   = r_state == RESP && !r_is_fetch && w_mem_ok;
`ifdef BUSIO_FETCH_HIT_EN
  logic                  r_hit_valid;
  logic [ADDR_WIDTH-3:0] r_hit_addr;
  logic [31:0]           r_hit_data;
  assign w_hit      = r_hit_valid && r_hit_addr == bus.fetch_address[ADDR_WIDTH-1:2];
  assign w_hit_data = r_hit_data;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_hit_valid <= 1'b0;
      r_hit_addr  <= '0;
      r_hit_data  <= '0;
    end else if (r_state == FETCH && bus.ext_ready) begin
      r_hit_valid <= 1'b1;
      r_hit_addr  <= r_addr[ADDR_WIDTH-1:2];
      r_hit_data  <= bus.ext_read_data;
    end else if (r_state == IDLE && bus.load_store && bus.mem_write &&
                 bus.mem_address[ADDR_WIDTH-1:2] == r_hit_addr)
      r_hit_valid <= 1'b0;
`else
  assign w_hit      = 1'b0;
  assign w_hit_data = 32'h0;
`endif
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_state              <= IDLE;
      r_is_fetch           <= 1'b0;
      r_signed             <= 1'b0;
      r_size               <= 2'd0;
      r_addr               <= '0;
      bus.ext_valid        <= 1'b0;
      bus.ext_instruction  <= 1'b0;
      bus.ext_write        <= 1'b0;
      bus.ext_address      <= '0;
      bus.ext_write_data   <= '0;
      bus.ext_write_strobe <= '0;
      bus.fetch_data       <= RESET_VECTOR;
      bus.mem_load_data    <= '0;
    end else if (r_state == IDLE) begin
      if (bus.load_store) begin
        r_state              <= MEM;
        r_is_fetch           <= 1'b0;
        r_signed             <= bus.mem_signed;
        r_size               <= bus.mem_size;
        r_addr               <= bus.mem_address;
        bus.ext_valid        <= 1'b1;
        bus.ext_instruction  <= 1'b0;
        bus.ext_write        <= bus.mem_write;
        bus.ext_address      <= {bus.mem_address[ADDR_WIDTH-1:2], 2'b00};
        bus.ext_write_data   <= w_wdata;
        bus.ext_write_strobe <= w_strobe;
      end else if (bus.fetch_request) begin
        r_is_fetch <= 1'b1;
        r_addr     <= bus.fetch_address;
        if (w_hit) begin
          r_state        <= RESP;
          bus.fetch_data <= w_hit_data;
        end else begin
          r_state              <= FETCH;
          bus.ext_valid        <= 1'b1;
          bus.ext_instruction  <= 1'b1;
          bus.ext_write        <= 1'b0;
          bus.ext_address      <= {bus.fetch_address[ADDR_WIDTH-1:2], 2'b00};
          bus.ext_write_data   <= '0;
          bus.ext_write_strobe <= '0;
        end
      end
    end else if (r_state == RESP)
      r_state <= IDLE;
    else if (bus.ext_ready) begin
      r_state       <= RESP;
      bus.ext_valid <= 1'b0;
      if (r_is_fetch)
        bus.fetch_data <= bus.ext_read_data;
      else
        bus.mem_load_data <= w_load;
    end
endmodule

// File: tb/tb_busio.sv
// tb_busio: directed literal checks plus randomized traffic compared every cycle against a transaction-level model.
module tb_busio;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  busio_if #(.ADDR_WIDTH(32)) bus ();
  busio #(.ADDR_WIDTH(32), .RESET_VECTOR(32'h0)) dut (.clk(clk), .reset_n(reset_n), .bus(bus.slave));
  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  function automatic int nbytes(input logic [1:0] s);
    return s >= 2 ? 4 : (s == 1 ? 2 : 1);
  endfunction
  function automatic int first_lane(input logic [1:0] s, input logic [31:0] a);
    int n = nbytes(s);
    return (int'(a % 4) / n) * n;
  endfunction
  function automatic logic [3:0] strobe_of(input logic [1:0] s, input logic [31:0] a);
    logic [3:0] r = '0;
    int st = first_lane(s, a);
    for (int i = 0; i < 4; i++) if (i >= st && i < st + nbytes(s)) r[i] = 1'b1;
    return r;
  endfunction
  function automatic logic [31:0] repl_of(input logic [1:0] s, input logic [31:0] d);
    logic [31:0] r;
    int n = nbytes(s);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % n) +: 8];
    return r;
  endfunction
  function automatic logic [31:0] load_of(input logic [1:0] s, input logic sg, input logic [31:0] a, input logic [31:0] rd);
    int n = nbytes(s);
    longint full = longint'(1) << (8 * n);
    longint v = (longint'(rd) >> (8 * first_lane(s, a))) % full;
    if (sg && v >= full / 2) v -= full;
    return v[31:0];
  endfunction

  // model: transaction phase is idle(0), on the bus(1) or responding(2)
  int ph;
  bit k_fetch;
  logic [31:0] l_addr;
  logic e_valid, e_instr, e_write;
  logic [31:0] e_addr, e_wdata, e_fdata, e_ldata;
  logic [3:0] e_strb;
`ifdef BUSIO_FETCH_HIT_EN
  bit c_valid;
  logic [29:0] c_addr;
  logic [31:0] c_data;
`endif
  logic [1:0] l_size;
  bit l_sgn;
  bit m_hit;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ph = 0; k_fetch = 0; l_addr = 0; l_size = 0; l_sgn = 0;
      e_valid = 0; e_instr = 0; e_write = 0; e_addr = 0; e_wdata = 0; e_strb = 0;
      e_fdata = 32'h0; e_ldata = 0;
`ifdef BUSIO_FETCH_HIT_EN
      c_valid = 0;
`endif
    end else if (ph == 2) ph = 0;
    else if (ph == 1) begin
      if (bus.ext_ready) begin
        ph = 2; e_valid = 0;
        if (k_fetch) begin
          e_fdata = bus.ext_read_data;
`ifdef BUSIO_FETCH_HIT_EN
          c_valid = 1; c_addr = l_addr[31:2]; c_data = bus.ext_read_data;
`endif
        end else e_ldata = load_of(l_size, l_sgn, l_addr, bus.ext_read_data);
      end
    end else if (bus.load_store) begin
`ifdef BUSIO_FETCH_HIT_EN
      if (bus.mem_write && c_addr == bus.mem_address[31:2]) c_valid = 0;
`endif
      ph = 1; k_fetch = 0; l_addr = bus.mem_address; l_size = bus.mem_size; l_sgn = bus.mem_signed;
      e_valid = 1; e_instr = 0; e_write = bus.mem_write; e_addr = bus.mem_address & ~32'h3;
      e_wdata = repl_of(bus.mem_size, bus.mem_store_data);
      e_strb = bus.mem_write ? strobe_of(bus.mem_size, bus.mem_address) : 4'h0;
    end else if (bus.fetch_request) begin
      k_fetch = 1; l_addr = bus.fetch_address; m_hit = 0;
`ifdef BUSIO_FETCH_HIT_EN
      m_hit = c_valid && c_addr == bus.fetch_address[31:2];
      if (m_hit) e_fdata = c_data;
`endif
      if (m_hit) ph = 2;
      else begin
        ph = 1; e_valid = 1; e_instr = 1; e_write = 0; e_addr = bus.fetch_address & ~32'h3; e_strb = 0;
      end
    end
  end

  always @(negedge clk) if (reset_n) begin
    bit ef, em;
    ef = ph == 2 && k_fetch && bus.fetch_request && bus.fetch_address[31:2] == l_addr[31:2];
    em = ph == 2 && !k_fetch && bus.load_store && bus.mem_address == l_addr;
    chk("m_ext_valid", 32'(bus.ext_valid), 32'(e_valid));
    chk("m_fetch_ready", 32'(bus.fetch_ready), 32'(ef));
    chk("m_mem_ready", 32'(bus.mem_ready), 32'(em));
    if (e_valid) begin
      chk("m_ext_address", bus.ext_address, e_addr);
      chk("m_ext_instruction", 32'(bus.ext_instruction), 32'(e_instr));
      chk("m_ext_write", 32'(bus.ext_write), 32'(e_write));
      chk("m_ext_strobe", 32'(bus.ext_write_strobe), 32'(e_strb));
      if (e_write) chk("m_ext_write_data", bus.ext_write_data, e_wdata);
    end
    if (ef) chk("m_fetch_data", bus.fetch_data, e_fdata);
    if (em && !e_write) chk("m_mem_load_data", bus.mem_load_data, e_ldata);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drop;
    bus.fetch_request = 0;
    bus.load_store = 0;
  endtask
  task automatic start_mem(input logic w, input logic [1:0] s, input logic sg, input logic [31:0] a, input logic [31:0] d);
    bus.load_store = 1; bus.mem_write = w; bus.mem_size = s; bus.mem_signed = sg;
    bus.mem_address = a; bus.mem_store_data = d;
    tick;
  endtask
  task automatic start_fetch(input logic [31:0] a);
    bus.fetch_request = 1; bus.fetch_address = a;
    tick;
  endtask

  initial begin
    bus.fetch_request = 0; bus.fetch_address = 0; bus.load_store = 0; bus.mem_write = 0;
    bus.mem_size = 0; bus.mem_signed = 0; bus.mem_address = 0; bus.mem_store_data = 0;
    bus.ext_read_data = 0; bus.ext_ready = 0;
    tick; tick;
    chk("rst_ext_valid", 32'(bus.ext_valid), 0);
    chk("rst_fetch_ready", 32'(bus.fetch_ready), 0);
    chk("rst_mem_ready", 32'(bus.mem_ready), 0);
    chk("rst_fetch_data", bus.fetch_data, 32'h0);
    chk("rst_mem_load_data", bus.mem_load_data, 0);
    chk("rst_ext_strobe", 32'(bus.ext_write_strobe), 0);
    reset_n = 1;
    tick;
    bus.ext_ready = 1; bus.ext_read_data = 32'h00000013;
    start_fetch(32'h100);
    chk("f_valid", 32'(bus.ext_valid), 1);
    chk("f_addr", bus.ext_address, 32'h100);
    chk("f_instr", 32'(bus.ext_instruction), 1);
    tick;
    chk("f_ready", 32'(bus.fetch_ready), 1);
    chk("f_data", bus.fetch_data, 32'h00000013);
    drop; tick;
    bus.fetch_request = 1; bus.fetch_address = 32'h104; bus.ext_read_data = 32'hCAFEF00D;
    start_mem(0, 2, 0, 32'h200, 0);
    chk("arb_addr", bus.ext_address, 32'h200);
    chk("arb_instr", 32'(bus.ext_instruction), 0);
    tick;
    chk("arb_mem_ready", 32'(bus.mem_ready), 1);
    chk("arb_load", bus.mem_load_data, 32'hCAFEF00D);
    chk("arb_no_fetch_ready", 32'(bus.fetch_ready), 0);
    bus.load_store = 0; tick; tick;
    chk("arb_fetch_addr", bus.ext_address, 32'h104);
    chk("arb_fetch_instr", 32'(bus.ext_instruction), 1);
    tick;
    chk("arb_fetch_ready", 32'(bus.fetch_ready), 1);
    drop; tick;
    bus.ext_read_data = 32'h80FF1234;
    start_mem(0, 0, 1, 32'h203, 0); tick;
    chk("lb_ready", 32'(bus.mem_ready), 1);
    chk("lb_signed", bus.mem_load_data, 32'hFFFFFF80);
    drop; tick;
    start_mem(0, 0, 0, 32'h203, 0); tick;
    chk("lbu_unsigned", bus.mem_load_data, 32'h00000080);
    drop; tick;
    start_mem(1, 1, 0, 32'h302, 32'h0000BEEF);
    chk("sh_addr", bus.ext_address, 32'h300);
    chk("sh_data", bus.ext_write_data, 32'hBEEFBEEF);
    chk("sh_strobe", 32'(bus.ext_write_strobe), 32'hC);
    chk("sh_write", 32'(bus.ext_write), 1);
    tick;
    chk("sh_ready", 32'(bus.mem_ready), 1);
    drop; tick;
    bus.ext_ready = 0;
    start_fetch(32'h140);
    bus.fetch_request = 0;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("ab_valid_held", 32'(bus.ext_valid), 1);
    end
    bus.ext_ready = 1; tick;
    chk("ab_no_ready", 32'(bus.fetch_ready), 0);
    chk("ab_valid_low", 32'(bus.ext_valid), 0);
    tick;
    bus.ext_ready = 0; bus.ext_read_data = 32'h11223344;
    start_mem(0, 2, 0, 32'h200, 0);
    chk("rs_valid_before", 32'(bus.ext_valid), 1);
    #2 reset_n = 0;
    #1;
    chk("rs_valid_async", 32'(bus.ext_valid), 0);
    chk("rs_no_ready", 32'(bus.mem_ready), 0);
    reset_n = 1; bus.ext_ready = 1;
    tick;
    chk("rs_restart_valid", 32'(bus.ext_valid), 1);
    tick;
    chk("rs_restart_ready", 32'(bus.mem_ready), 1);
    chk("rs_restart_data", bus.mem_load_data, 32'h11223344);
    drop; tick;
`ifdef BUSIO_FETCH_HIT_EN
    bus.ext_read_data = 32'h00000013;
    start_fetch(32'h100); tick; drop; tick;
    bus.ext_read_data = 32'hDEADBEEF;
    start_fetch(32'h100);
    chk("hit_ready", 32'(bus.fetch_ready), 1);
    chk("hit_valid_low", 32'(bus.ext_valid), 0);
    chk("hit_data", bus.fetch_data, 32'h00000013);
    drop; tick;
    start_mem(1, 2, 0, 32'h100, 32'h12345678); tick; drop; tick;
    start_fetch(32'h100);
    chk("inv_to_bus", 32'(bus.ext_valid), 1);
    tick; drop; tick;
`endif
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.fetch_request = 1'($urandom_range(0, 1));
        bus.fetch_address = 32'h100 + 32'(4 * $urandom_range(0, 3)) + 32'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 3) == 0) begin
        bus.load_store = 1'($urandom_range(0, 1));
        bus.mem_write = 1'($urandom_range(0, 1));
        bus.mem_size = 2'($urandom_range(0, 3));
        bus.mem_signed = 1'($urandom_range(0, 1));
        bus.mem_address = 32'h100 + 32'($urandom_range(0, 15));
        bus.mem_store_data = $urandom;
      end
      bus.ext_ready = $urandom_range(0, 2) != 0;
      bus.ext_read_data = $urandom;
      if ($urandom_range(0, 499) == 0) begin
        #2 reset_n = 0;
        #1 reset_n = 1;
      end
      tick;
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
